// File: rtl/toysram_scan_ctl.sv
// Scan-chain sequencer for the toy SRAM macros: shifts a load vector into
// CHAINS parallel chains, captures what falls out, and optionally compares it.
module toysram_scan_ctl #(
  parameter int SCAN_LEN = 128,
  parameter int CHAINS   = 1,
  parameter int CLK_DIV  = 2,
  parameter int CNT_W    = $clog2(SCAN_LEN*CHAINS+1)
) (
  input  logic                         clock,
  input  logic                         resetb,
  input  logic                         start,
  input  logic                         compare,
  input  logic                         abort,
  input  logic [SCAN_LEN*CHAINS-1:0]   load_data,
  input  logic [SCAN_LEN*CHAINS-1:0]   expect_data,
  input  logic [SCAN_LEN*CHAINS-1:0]   expect_mask,
  input  logic [CHAINS-1:0]            scan_out,
  output logic                         te,
  output logic                         scan_clk,
  output logic [CHAINS-1:0]            scan_in,
  output logic                         busy,
  output logic                         done,
  output logic                         aborted,
  output logic [SCAN_LEN*CHAINS-1:0]   capture_data,
  output logic [CNT_W-1:0]             mismatch_cnt,
  output logic                         pass
);
  localparam int TOT   = SCAN_LEN*CHAINS;
  localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(SCAN_LEN);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV-1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SCAN_LEN-1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LOW, S_HIGH, S_HOLD, S_CMP} state_t;

  state_t              state_q;
  logic [PH_W-1:0]     phase_q;
  logic [BIT_W-1:0]    bit_q;
  logic                te_q, sclk_q, busy_q, done_q, aborted_q, pass_q;
  logic [CHAINS-1:0]   sin_q;
  logic [TOT-1:0]      cap_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [TOT-1:0]      load_q, expect_q, mask_q;
  logic                compare_q;

  function automatic logic [CNT_W-1:0] popcount(input logic [TOT-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < TOT; i++) n = n + {{(CNT_W-1){1'b0}}, v[i]};
    return n;
  endfunction

  // Bit k of every chain, gathered into one scan_in word.
  function automatic logic [CHAINS-1:0] head_bits(input logic [TOT-1:0] v,
                                                  input logic [BIT_W-1:0] k);
    logic [CHAINS-1:0]   h;
    logic [SCAN_LEN-1:0] sh;
    h = '0;
    for (int c = 0; c < CHAINS; c++) begin
      sh   = v[c*SCAN_LEN +: SCAN_LEN] >> k;
      h[c] = sh[0];
    end
    return h;
  endfunction

  logic                phase_last;
  logic [SCAN_LEN-1:0] bit_oh;
  logic [CNT_W-1:0]    cmp_cnt;

  assign phase_last = (phase_q == PH_LAST);
  assign bit_oh     = {{(SCAN_LEN-1){1'b0}}, 1'b1} << bit_q;
  assign cmp_cnt    = compare_q ? popcount((cap_q ^ expect_q) & mask_q) : '0;

  always_ff @(posedge clock) begin
    if (state_q == S_IDLE && start) begin
      load_q    <= load_data;
      expect_q  <= expect_data;
      mask_q    <= expect_mask;
      compare_q <= compare;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      bit_q     <= '0;
      te_q      <= 1'b0;
      sclk_q    <= 1'b0;
      sin_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      cap_q     <= '0;
      cnt_q     <= '0;
      pass_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (busy_q && abort) begin
        state_q   <= S_IDLE;
        phase_q   <= '0;
        bit_q     <= '0;
        te_q      <= 1'b0;
        sclk_q    <= 1'b0;
        sin_q     <= '0;
        busy_q    <= 1'b0;
        done_q    <= 1'b1;
        aborted_q <= 1'b1;
        cnt_q     <= '0;
        pass_q    <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q   <= S_SETUP;
              phase_q   <= '0;
              bit_q     <= '0;
              busy_q    <= 1'b1;
              te_q      <= 1'b1;
              sclk_q    <= 1'b0;
              sin_q     <= head_bits(load_data, '0);
              aborted_q <= 1'b0;
              cap_q     <= '0;
            end
          end
          S_SETUP: begin
            if (phase_last) begin
              phase_q <= '0;
              state_q <= S_LOW;
            end else phase_q <= phase_q + 1'b1;
          end
          S_LOW: begin
            // This edge raises scan_clk, so it is the one that samples scan_out.
            if (phase_last) begin
              phase_q <= '0;
              state_q <= S_HIGH;
              sclk_q  <= 1'b1;
              for (int c = 0; c < CHAINS; c++)
                cap_q[c*SCAN_LEN +: SCAN_LEN] <= cap_q[c*SCAN_LEN +: SCAN_LEN]
                                                 | ({SCAN_LEN{scan_out[c]}} & bit_oh);
            end else phase_q <= phase_q + 1'b1;
          end
          S_HIGH: begin
            if (phase_last) begin
              phase_q <= '0;
              sclk_q  <= 1'b0;
              if (bit_q == BIT_LAST) begin
                state_q <= S_HOLD;
              end else begin
                bit_q   <= bit_q + 1'b1;
                sin_q   <= head_bits(load_q, bit_q + 1'b1);
                state_q <= S_LOW;
              end
            end else phase_q <= phase_q + 1'b1;
          end
          S_HOLD: begin
            if (phase_last) begin
              phase_q <= '0;
              te_q    <= 1'b0;
              state_q <= S_CMP;
            end else phase_q <= phase_q + 1'b1;
          end
          S_CMP: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= cmp_cnt;
            pass_q  <= (cmp_cnt == '0);
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign te           = te_q;
  assign scan_clk     = sclk_q;
  assign scan_in      = sin_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign aborted      = aborted_q;
  assign capture_data = cap_q;
  assign mismatch_cnt = cnt_q;
  assign pass         = pass_q;
endmodule

// File: tb/tb_toysram_scan_ctl.sv
// Bench for toysram_scan_ctl: default instance (1x128, div 2) and a 4x16 div-1 instance,
// with expectations queued at stimulus time and scored when done appears.
module tb_toysram_scan_ctl;
  localparam int L0 = 128, C0 = 1, D0 = 2;
  localparam int L1 = 16,  C1 = 4, D1 = 1;
  localparam int CW0 = $clog2(L0*C0+1);
  localparam int CW1 = $clog2(L1*C1+1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              start0, cmp0, abort0, te0, sclk0, busy0, done0, ab0, pass0;
  logic [L0*C0-1:0]  load0, exp0, mask0, cap0;
  logic [C0-1:0]     sout0, sin0;
  logic [CW0-1:0]    mm0;
  logic              start1, cmp1, abort1, te1, sclk1, busy1, done1, ab1, pass1;
  logic [L1*C1-1:0]  load1, exp1, mask1, cap1;
  logic [C1-1:0]     sout1, sin1;
  logic [CW1-1:0]    mm1;

  toysram_scan_ctl #(.SCAN_LEN(L0), .CHAINS(C0), .CLK_DIV(D0)) dut0 (
    .clock(clk), .resetb(rst_n), .start(start0), .compare(cmp0), .abort(abort0),
    .load_data(load0), .expect_data(exp0), .expect_mask(mask0), .scan_out(sout0),
    .te(te0), .scan_clk(sclk0), .scan_in(sin0), .busy(busy0), .done(done0),
    .aborted(ab0), .capture_data(cap0), .mismatch_cnt(mm0), .pass(pass0));

  toysram_scan_ctl #(.SCAN_LEN(L1), .CHAINS(C1), .CLK_DIV(D1)) dut1 (
    .clock(clk), .resetb(rst_n), .start(start1), .compare(cmp1), .abort(abort1),
    .load_data(load1), .expect_data(exp1), .expect_mask(mask1), .scan_out(sout1),
    .te(te1), .scan_clk(sclk1), .scan_in(sin1), .busy(busy1), .done(done1),
    .aborted(ab1), .capture_data(cap1), .mismatch_cnt(mm1), .pass(pass1));

  // Behavioural 128-flop chain: head at the top, tail (scan_out) at bit 0.
  logic [L0-1:0] ch0, pre0;
  logic          ld0, mode0;
  always @(posedge sclk0 or posedge ld0)
    if (ld0) ch0 <= pre0;
    else     ch0 <= {sin0[0], ch0[L0-1:1]};
  assign sout0 = mode0 ? ch0[0] : sin0;
  assign sout1 = sin1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] cap;
    int cnt; bit pss; bit ab;
    int t0; int lat; bit full;
    int rises; int tec; int bc; int hic;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  int nchk = 0, nfail = 0;
  int bc[2], tec[2], hic[2], rise[2], ndone[2];
  bit psc[2];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    nchk++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic score(input int id, input logic [127:0] cap, input int cnt,
                       input logic p, input logic a, input logic b, input logic t,
                       input logic s);
    exp_t e;
    if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
      nchk++; nfail++;
      $display("FAIL dut%0d unexpected_done: got done=1 required no done", id);
      return;
    end
    if (id == 0) e = q0.pop_front(); else e = q1.pop_front();
    chk($sformatf("dut%0d capture", id), cap, e.cap);
    chk($sformatf("dut%0d mismatch_cnt", id), cnt, e.cnt);
    chk($sformatf("dut%0d pass", id), p, e.pss);
    chk($sformatf("dut%0d aborted", id), a, e.ab);
    chk($sformatf("dut%0d idle_outs(busy,te,sclk)", id), {b, t, s}, 3'b000);
    chk($sformatf("dut%0d latency", id), cyc - e.t0, e.lat);
    if (e.full) begin
      chk($sformatf("dut%0d scan_clk_rises", id), rise[id], e.rises);
      chk($sformatf("dut%0d scan_clk_high_cycles", id), hic[id], e.hic);
      chk($sformatf("dut%0d te_cycles", id), tec[id], e.tec);
      chk($sformatf("dut%0d busy_cycles", id), bc[id], e.bc);
    end
  endtask

  task automatic mon_step(input int id, input logic b, input logic t, input logic s,
                          input logic d, input logic [127:0] cap, input int cnt,
                          input logic p, input logic a);
    if (d) begin
      ndone[id]++;
      score(id, cap, cnt, p, a, b, t, s);
    end
    if (d || !b) begin
      bc[id] = 0; tec[id] = 0; hic[id] = 0; rise[id] = 0;
    end else begin
      bc[id]++;
      if (t) tec[id]++;
      if (s) hic[id]++;
      if (s && !psc[id]) rise[id]++;
    end
    psc[id] = s;
  endtask

  always @(negedge clk) begin
    mon_step(0, busy0, te0, sclk0, done0, cap0, int'(mm0), pass0, ab0);
    mon_step(1, busy1, te1, sclk1, done1, {64'h0, cap1}, int'(mm1), pass1, ab1);
  end

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic op0(input logic [127:0] ld, input logic [127:0] ex,
                     input logic [127:0] mk, input logic cm, input bit push);
    exp_t e;
    logic [127:0] src;
    @(negedge clk);
    src = mode0 ? ch0 : ld;
    start0 = 1'b1; cmp0 = cm; load0 = ld; exp0 = ex; mask0 = mk;
    if (push) begin
      e.cap = src;
      e.cnt = cm ? $countones((src ^ ex) & mk) : 0;
      e.pss = (e.cnt == 0); e.ab = 1'b0; e.t0 = cyc;
      e.lat = 1 + D0*(2*L0+2) + 1; e.full = 1'b1; e.rises = L0;
      e.tec = D0*(2*L0+2); e.bc = D0*(2*L0+2) + 1; e.hic = L0*D0;
      q0.push_back(e);
    end
    @(negedge clk);
    start0 = 1'b0; load0 = rnd128(); exp0 = rnd128(); mask0 = rnd128(); cmp0 = ~cm;
  endtask

  task automatic op1(input logic [63:0] ld, input logic [63:0] ex,
                     input logic [63:0] mk, input logic cm);
    exp_t e;
    @(negedge clk);
    start1 = 1'b1; cmp1 = cm; load1 = ld; exp1 = ex; mask1 = mk;
    e.cap = {64'h0, ld};
    e.cnt = cm ? $countones((ld ^ ex) & mk) : 0;
    e.pss = (e.cnt == 0); e.ab = 1'b0; e.t0 = cyc;
    e.lat = 1 + D1*(2*L1+2) + 1; e.full = 1'b1; e.rises = L1;
    e.tec = D1*(2*L1+2); e.bc = D1*(2*L1+2) + 1; e.hic = L1*D1;
    q1.push_back(e);
    @(negedge clk);
    start1 = 1'b0; load1 = {$urandom(), $urandom()}; cmp1 = ~cm;
  endtask

  task automatic wait_done(input int id, input int lim);
    int n;
    n = 0;
    while (n < lim && !(id == 0 ? done0 : done1)) begin
      @(negedge clk);
      n++;
    end
    nchk++;
    if (n >= lim) begin
      nfail++;
      $display("FAIL dut%0d done_timeout: got no done in %0d cycles required done", id, lim);
      if (id == 0) q0.delete(); else q1.delete();
    end
  endtask

  task automatic preload(input logic [127:0] v);
    @(negedge clk);
    pre0 = v; ld0 = 1'b1;
    #1 ld0 = 1'b0;
  endtask

  initial begin
    logic [127:0] ld, ex, mk, pat;
    logic [63:0]  l1;
    exp_t e;
    int k, n;
    start0 = 0; cmp0 = 0; abort0 = 0; load0 = '0; exp0 = '0; mask0 = '0;
    start1 = 0; cmp1 = 0; abort1 = 0; load1 = '0; exp1 = '0; mask1 = '0;
    mode0 = 1'b0; ld0 = 1'b0; pre0 = '0;
    repeat (3) @(negedge clk);
    chk("reset dut0 ctl(te,sclk,sin,busy,done,ab,pass)",
        {te0, sclk0, sin0, busy0, done0, ab0, pass0}, '0);
    chk("reset dut0 capture", cap0, '0);
    chk("reset dut0 mismatch_cnt", mm0, '0);
    chk("reset dut1 ctl(te,sclk,sin,busy,done,ab,pass)",
        {te1, sclk1, sin1, busy1, done1, ab1, pass1}, '0);
    chk("reset dut1 capture/cnt", {cap1, mm1}, '0);
    rst_n = 1'b1;

    // Loopback with the fixed pattern
    pat = 128'h0123456789ABCDEFFEDCBA9876543210;
    op0(pat, pat, '1, 1'b1, 1'b1);
    wait_done(0, 1000);

    // Behavioural chain: capture its preload, leave load_data behind
    mode0 = 1'b1;
    pat = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    preload(pat);
    ld = rnd128();
    op0(ld, pat, '1, 1'b1, 1'b1);
    wait_done(0, 1000);
    chk("chain holds load_data", ch0, ld);
    preload(pat);
    op0(rnd128(), pat ^ (128'd1 << 5), '1, 1'b1, 1'b1);
    wait_done(0, 1000);
    preload(pat);
    op0(rnd128(), pat ^ (128'd1 << 5), ~(128'd1 << 5), 1'b1, 1'b1);
    wait_done(0, 1000);
    mode0 = 1'b0;

    // Random loopback with sparse expect corruption and random masks
    for (int i = 0; i < 4; i++) begin
      ld = rnd128();
      ex = ld ^ (rnd128() & rnd128() & rnd128());
      mk = rnd128();
      op0(ld, ex, mk, 1'($urandom_range(0, 1)), 1'b1);
      wait_done(0, 1000);
    end

    // Four chains, per-chain loopback
    l1 = {16'h0001, 16'hFFFF, 16'h0F0F, 16'hA5A5};
    op1(l1, l1, '1, 1'b1);
    wait_done(1, 100);
    for (int i = 0; i < 3; i++) begin
      l1 = {$urandom(), $urandom()};
      op1(l1, l1 ^ ({$urandom(), $urandom()} & {$urandom(), $urandom()}),
          {$urandom(), $urandom()}, 1'($urandom_range(0, 1)));
      wait_done(1, 100);
    end

    // Abort after ten scan_clk rises
    ld = rnd128();
    op0(ld, ld, '1, 1'b1, 1'b0);
    n = 0;
    while (rise[0] < 10 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("abort reached 10 rises", rise[0], 10);
    abort0 = 1'b1;
    e.cap = ld & ((128'd1 << 10) - 1); e.cnt = 0; e.pss = 1'b0; e.ab = 1'b1;
    e.t0 = cyc; e.lat = 1; e.full = 1'b0; e.rises = 0; e.tec = 0; e.bc = 0; e.hic = 0;
    q0.push_back(e);
    @(negedge clk);
    abort0 = 1'b0;
    wait_done(0, 10);
    op0(rnd128(), rnd128(), rnd128(), 1'b1, 1'b1);
    wait_done(0, 1000);

    // Start while busy is ignored: exactly one done
    op0(rnd128(), rnd128(), '0, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    k = ndone[0];
    start0 = 1'b1; load0 = rnd128();
    @(negedge clk);
    start0 = 1'b0;
    wait_done(0, 1000);
    repeat (600) @(negedge clk);
    chk("busy start gives single done", ndone[0] - k, 1);

    // Start and abort together in IDLE: start wins
    abort0 = 1'b1;
    op0(rnd128(), rnd128(), rnd128(), 1'b1, 1'b1);
    abort0 = 1'b0;
    wait_done(0, 1000);

    // Asynchronous reset mid-shift
    op0(rnd128(), rnd128(), rnd128(), 1'b1, 1'b0);
    repeat (100) @(negedge clk);
    chk("busy before reset", busy0, 1'b1);
    k = ndone[0];
    #2 rst_n = 1'b0;
    #1;
    chk("async reset ctl(te,sclk,sin,busy,done,ab,pass)",
        {te0, sclk0, sin0, busy0, done0, ab0, pass0}, '0);
    chk("async reset capture/cnt", {cap0, mm0}, '0);
    repeat (5) @(negedge clk);
    chk("no done across reset", ndone[0] - k, 0);
    rst_n = 1'b1;
    op0(rnd128(), rnd128(), rnd128(), 1'b1, 1'b1);
    wait_done(0, 1000);
    op1({$urandom(), $urandom()}, {$urandom(), $urandom()}, '1, 1'b1);
    wait_done(1, 100);

    repeat (4) @(negedge clk);
    chk("scoreboard drained", q0.size() + q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
